// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM port between display fetch, PVR and CPU with starvation forcing
module vram_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_gnt,
  output logic                d_ack,
  input  logic                p_req,
  input  logic                p_we,
  input  logic [ADDR_W-1:0]   p_addr,
  input  logic [DATA_W-1:0]   p_wdata,
  input  logic [DATA_W/8-1:0] p_wmask,
  output logic                p_gnt,
  output logic                p_ack,
  input  logic                c_req,
  input  logic                c_we,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_wdata,
  input  logic [DATA_W/8-1:0] c_wmask,
  output logic                c_gnt,
  output logic                c_ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  localparam logic [1:0] W_D = 2'd0, W_P = 2'd1, W_C = 2'd2;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [1:0] owner, win;
  logic rr;
  logic [CW-1:0] cnt_p, cnt_c;
  logic force_p, force_c, any_req, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W/8-1:0] sel_wmask;
  // rr = 0 favours PVR, rr = 1 favours CPU when both are pending
  always_comb begin
    force_p = p_req && cnt_p == LIM;
    force_c = c_req && cnt_c == LIM;
    any_req = d_req || p_req || c_req;
    win = force_p ? W_P : force_c ? W_C : d_req ? W_D :
          (p_req && c_req) ? (rr ? W_C : W_P) : p_req ? W_P : W_C;
    sel_we    = win == W_D ? d_we    : win == W_P ? p_we    : c_we;
    sel_addr  = win == W_D ? d_addr  : win == W_P ? p_addr  : c_addr;
    sel_wdata = win == W_D ? d_wdata : win == W_P ? p_wdata : c_wdata;
    sel_wmask = win == W_D ? d_wmask : win == W_P ? p_wmask : c_wmask;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= W_D;
      rr <= 1'b0;
      cnt_p <= '0;
      cnt_c <= '0;
      {d_gnt, p_gnt, c_gnt} <= '0;
      {d_ack, p_ack, c_ack} <= '0;
      rdata <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      {d_gnt, p_gnt, c_gnt} <= '0;
      {d_ack, p_ack, c_ack} <= '0;
      if (!p_req) cnt_p <= '0;
      if (!c_req) cnt_c <= '0;
      if (state == IDLE && any_req) begin
        d_gnt <= win == W_D;
        p_gnt <= win == W_P;
        c_gnt <= win == W_C;
        owner <= win;
        mem_req <= 1'b1;
        mem_we <= sel_we;
        mem_addr <= sel_addr & ~(ADDR_W'(7));
        mem_wdata <= sel_wdata;
        mem_wmask <= sel_wmask;
        state <= BUSY;
        if (win == W_P) begin
          rr <= 1'b1;
          cnt_p <= '0;
        end else if (p_req && cnt_p != LIM) cnt_p <= cnt_p + 1'b1;
        if (win == W_C) begin
          rr <= 1'b0;
          cnt_c <= '0;
        end else if (c_req && cnt_c != LIM) cnt_c <= cnt_c + 1'b1;
      end else if (state == BUSY && mem_ack) begin
        mem_req <= 1'b0;
        mem_we <= 1'b0;
        if (!mem_we) rdata <= mem_rdata;
        d_ack <= owner == W_D;
        p_ack <= owner == W_P;
        c_ack <= owner == W_C;
        state <= IDLE;
      end
    end
  end
endmodule
